// File: rtl/apb_pkg.sv
// apb_pkg: APB bus defaults and slave FSM state encoding shared by the APB master and slave.
`default_nettype none

package apb_pkg;

   localparam int APB_ADDR_WIDTH = 10;
   localparam int APB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WAIT  = 2'b01,
      ST_READY = 2'b10
   } apb_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: DEPTH x DATA_WIDTH storage, synchronous write, combinational read.
`default_nettype none

module apb_slave_regfile #(
   parameter int DEPTH      = 256,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDX_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   // Contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave backed by a word-addressed memory; out-of-range accesses return pslverr.
// Optional wait-state insertion is enabled with macro APB_SLV_WAIT_EN (WAIT_CYCLES per transfer).
`default_nettype none

module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH  = APB_DATA_WIDTH,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  pselx,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic                  pready,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pslverr
);

   localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   apb_state_e            state_q, state_d;
   logic [IDX_W-1:0]      addr_q, addr_d;
   logic                  write_q, write_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  pready_q, pready_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  pslverr_q, pslverr_d;

   logic                  setup;
   logic                  paddr_err;
   logic                  mem_we;
   logic [IDX_W-1:0]      rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;

`ifdef APB_SLV_WAIT_EN
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
   logic [3:0] wait_cnt_q, wait_cnt_d;
`else
   logic [31:0] unused_wait_cycles;
   assign unused_wait_cycles = 32'(WAIT_CYCLES);
`endif

   assign setup = pselx & ~penable;
   // Full-width compare so high address bits can never alias into the array.
   assign paddr_err = ({1'b0, paddr} >= DEPTH_EXT);

   // Read data is registered on entry to READY, so look at the live address in IDLE.
   assign rd_idx = (state_q == ST_IDLE) ? paddr[IDX_W-1:0] : addr_q;
   assign mem_we = (state_q == ST_READY) & pselx & write_q & ~err_q;

   apb_slave_regfile #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_regfile (
      .clk   (clk),
      .we    (mem_we),
      .waddr (addr_q),
      .wdata (wdata_q),
      .raddr (rd_idx),
      .rdata (rd_word)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         write_q    <= 1'b0;
         err_q      <= 1'b0;
         wdata_q    <= '0;
         pready_q   <= 1'b0;
         prdata_q   <= '0;
         pslverr_q  <= 1'b0;
`ifdef APB_SLV_WAIT_EN
         wait_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         err_q      <= err_d;
         wdata_q    <= wdata_d;
         pready_q   <= pready_d;
         prdata_q   <= prdata_d;
         pslverr_q  <= pslverr_d;
`ifdef APB_SLV_WAIT_EN
         wait_cnt_q <= wait_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      write_d    = write_q;
      err_d      = err_q;
      wdata_d    = wdata_q;
`ifdef APB_SLV_WAIT_EN
      wait_cnt_d = wait_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (setup) begin
               addr_d  = paddr[IDX_W-1:0];
               write_d = pwrite;
               err_d   = paddr_err;
               wdata_d = pwdata;
`ifdef APB_SLV_WAIT_EN
               if (WAIT_LOAD != 4'd0) begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = WAIT_LOAD;
               end else begin
                  state_d = ST_READY;
               end
`else
               state_d = ST_READY;
`endif
            end
         end
         ST_WAIT: begin
`ifdef APB_SLV_WAIT_EN
            if (!pselx) begin
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == 4'd1) begin
               state_d    = ST_READY;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_READY: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered: decide them from the state being entered.
   always_comb begin
      pready_d  = 1'b0;
      prdata_d  = '0;
      pslverr_d = 1'b0;
      if (state_d == ST_READY) begin
         pready_d  = 1'b1;
         pslverr_d = err_d;
         if (!write_d && !err_d) begin
            prdata_d = rd_word;
         end
      end
   end

   assign pready  = pready_q;
   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: scoreboard bench for apb_slave_mem; honours APB_SLV_WAIT_EN when defined.
`default_nettype none

module tb_apb_slave_mem;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int DEPTH = 256;
   localparam int WAITS = 2;
`ifdef APB_SLV_WAIT_EN
   localparam int NWAIT = WAITS;
`else
   localparam int NWAIT = 0;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          pselx = 1'b0;
   logic          penable = 1'b0;
   logic          pwrite = 1'b0;
   logic [AW-1:0] paddr = '0;
   logic [DW-1:0] pwdata = '0;
   logic          pready;
   logic [DW-1:0] prdata;
   logic          pslverr;

   typedef struct packed {
      logic          err;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] model [0:DEPTH-1];
   int            n_cmp = 0;
   int            n_mis = 0;

   apb_slave_mem #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (WAITS)
   ) dut (
      .clk     (clk),
      .resetn  (resetn),
      .pselx   (pselx),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pready  (pready),
      .prdata  (prdata),
      .pslverr (pslverr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called just after a negedge; leaves the bus idle one cycle after pready so
   // consecutive calls run back-to-back.
   task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input string tag);
      exp_t e;
      int   cyc;
      e.err  = (addr >= AW'(DEPTH));
      e.data = (!wr && !e.err) ? model[addr[7:0]] : '0;
      sb.push_back(e);
      if (wr && !e.err) model[addr[7:0]] = data;

      pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      @(negedge clk);
      penable = 1'b1;
      cyc = 1;
      while (!pready && cyc < 32) begin
         @(negedge clk);
         cyc++;
      end
      if (!pready) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         void'(sb.pop_front());
      end else begin
         chk({tag, "_latency"}, DW'(cyc), DW'(1 + NWAIT));
         e = sb.pop_front();
         chk({tag, "_prdata"}, prdata, e.data);
         chk({tag, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
      end
      @(negedge clk);
      chk({tag, "_pready_drop"}, {31'd0, pready}, 32'd0);
      pselx = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic seen;

      repeat (3) @(negedge clk);
      chk("rst_pready", {31'd0, pready}, 32'd0);
      chk("rst_prdata", prdata, 32'd0);
      chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      apb_xfer(1'b1, 10'h005, 32'hDEADBEEF, "wr5");
      apb_xfer(1'b0, 10'h005, 32'h0, "rd5");

      apb_xfer(1'b1, 10'h000, 32'hCAFE0000, "wr0");
      apb_xfer(1'b1, 10'h100, 32'h12345678, "wr_oor");
      apb_xfer(1'b0, 10'h000, 32'h0, "rd0");
      apb_xfer(1'b0, 10'h3FF, 32'h0, "rd_3ff");
      apb_xfer(1'b0, 10'h0FF, 32'h0, "rd_ff_pre");

      apb_xfer(1'b1, 10'h001, 32'h1, "b2b_wr1");
      apb_xfer(1'b1, 10'h002, 32'h2, "b2b_wr2");
      apb_xfer(1'b0, 10'h001, 32'h0, "b2b_rd1");
      apb_xfer(1'b0, 10'h002, 32'h0, "b2b_rd2");

      // Reset asserted while the write to addr 7 is in flight.
      apb_xfer(1'b1, 10'h007, 32'h0BADF00D, "wr7");
      pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h007; pwdata = 32'hAAAA5555;
      @(negedge clk);
      penable = 1'b1;
      resetn = 1'b0;
      #1;
      chk("midrst_pready", {31'd0, pready}, 32'd0);
      chk("midrst_pslverr", {31'd0, pslverr}, 32'd0);
      chk("midrst_prdata", prdata, 32'd0);
      pselx = 1'b0; penable = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      apb_xfer(1'b0, 10'h007, 32'h0, "rd7_after_rst");

      // pselx withdrawn right after the setup edge (WAIT, or READY without waits).
      apb_xfer(1'b1, 10'h009, 32'h00000099, "wr9");
      pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h009; pwdata = 32'h00000055;
      @(negedge clk);
      penable = 1'b1;
      pselx = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | pready;
      end
      chk("drop_no_pready", {31'd0, seen}, 32'd0);
      penable = 1'b0;
      apb_xfer(1'b0, 10'h009, 32'h0, "rd9_after_drop");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB slave that sits directly downstream of the team's APB master.
- It decodes pselx/penable/pwrite/paddr/pwdata and services transfers against an internal word-addressed memory.
- It returns pready, prdata and pslverr to the master.
- Wait-state insertion is optional; out-of-range accesses raise pslverr.

Parameters:
- ADDR_WIDTH, 10, width of paddr in bits. paddr is a word index, not a byte address.
- DATA_WIDTH, 32, width of pwdata and prdata in bits.
- DEPTH, 256, number of memory words. Valid word indices are 0..DEPTH-1. Must satisfy DEPTH <= 2**ADDR_WIDTH.
- WAIT_CYCLES, 2, number of wait states inserted per transfer. Takes effect only when APB_SLV_WAIT_EN is defined. Range 0..15.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- pselx  in  1  slave select from the master.
- penable  in  1  access-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  word address.
- pwdata  in  DATA_WIDTH  write data.
- pready  out  1  transfer-complete strobe.
- prdata  out  DATA_WIDTH  read data; valid only while pready=1.
- pslverr  out  1  error response; valid only while pready=1.

Behaviour:
- Reset values: pready=0, prdata=0, pslverr=0, state=IDLE, wait counter=0.
- Memory contents are not reset.
- All outputs are registered. No output depends combinationally on any input.
- States:
  - IDLE: a sampled setup phase (pselx=1, penable=0) captures paddr, pwrite, pwdata and the error flag err = (paddr >= DEPTH). Next state is WAIT if the wait count is nonzero, otherwise READY. Any other input combination stays in IDLE.
  - WAIT: the counter loads WAIT_CYCLES on entry and decrements each cycle. Moves to READY on the edge where the counter equals 1.
  - READY: pready=1 for exactly one cycle. On that edge:
    - If the captured write is valid and err=0, memory[addr] <= captured pwdata.
    - State returns to IDLE.
- READY outputs:
  - Read with err=0: prdata = memory[addr] as the word stood at capture time.
  - err=1: prdata=0 and pslverr=1. A write is suppressed.
  - Write: prdata=0.
- Outside READY, pready=0, pslverr=0 and prdata=0.
- Timing:
  - Zero-wait transfer: setup at cycle T, pready=1 at T+1, giving a 2-cycle transfer.
  - With N wait states: pready=1 at T+1+N.
- Protocol violation: if pselx drops in WAIT or READY, abort to IDLE with no write and pready=0 on the next cycle.
- Reset mid-transfer: return immediately to IDLE with no memory write. Outputs take their reset values.
- Back-to-back transfers: a new setup is accepted in the IDLE cycle that follows READY.
- Address bits above log2(DEPTH) are checked by the error flag, never truncated.

Optional Feature:
- Macro: APB_SLV_WAIT_EN.
- Defined: WAIT_CYCLES wait states are inserted per transfer as described above. WAIT_CYCLES=0 behaves as zero-wait.
- Undefined: the WAIT state and counter are not compiled. IDLE goes straight to READY and every transfer is 2 cycles.

Decomposition:
- Shared package apb_pkg:
  - ADDR_WIDTH and DATA_WIDTH defaults, shared with the master.
  - State encoding: IDLE=2'b00, WAIT=2'b01, READY=2'b10.
- Sub-module apb_slave_regfile:
  - DEPTH x DATA_WIDTH array.
  - Synchronous write with write enable.
  - Combinational read port.
  - The FSM stays in apb_slave_mem.

Test Plan:
- Reset then write: write 0xDEADBEEF to addr 0x005, then read addr 0x005 -> prdata=0xDEADBEEF, pslverr=0. With the macro undefined, pready=1 on the cycle after setup.
- Wait states: APB_SLV_WAIT_EN defined, WAIT_CYCLES=2 -> pready rises exactly 3 cycles after the setup cycle, stays high 1 cycle, data correct.
- Out of range: write 0x12345678 to addr 0x100 (DEPTH=256) -> pslverr=1 with pready. A later read of addr 0x000 shows no corruption. A read of 0x3FF -> prdata=0, pslverr=1.
- Back-to-back: write addr 1 = 0x1, write addr 2 = 0x2, read 1, read 2 with no idle gaps beyond protocol -> reads return 0x1 and 0x2.
- Reset mid-transfer: assert resetn=0 during WAIT of a write of 0xAAAA5555 to addr 7 -> pready=0 immediately, and after release a read of addr 7 returns its previous value.
- pselx dropped during WAIT -> FSM returns to IDLE, no pready pulse, no write.
